// File: rtl/render_scheduler.sv
// render_scheduler
//   Sequences one frame of work across three clients: game logic, then the
//   first-person view renderer, then (optionally) the minimap renderer.
//   Frame ticks that arrive while a frame is in flight are buffered once
//   (pending). Any further ticks in the same frame are counted as drops.
//   Each WAIT state has a watchdog. If a client never reports done, the
//   watchdog expires, the sticky error flag is set and the frame is closed.
//
// Handshake: the scheduler issues a one-cycle x_start_o pulse while it is in
//   state X_START. The client answers with a one-cycle x_done_i pulse. That
//   pulse is accepted only while the scheduler is in X_WAIT. A done pulse at
//   any other time, including the START cycle, is ignored.
//
// Ports
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   frame_tick_i                      one-cycle new-frame request
//   enable_map_i                      1 = run minimap after the FPV pass
//   *_start_o / *_done_i              client start pulses / done pulses
//   *_grid_x_i/*_grid_y_i             client grid addresses
//   grid_x_o/grid_y_o                 grid address of the owning client
//   fpv_vga_* / map_vga_*             client VGA write ports
//   vga_x_o/vga_y_o/vga_colour_o/vga_write_o  VGA port of the owning client
//   busy_o                            high whenever not IDLE
//   frame_count_o                     completed frames (wraps)
//   drop_count_o                      dropped ticks (saturates)
//   wdog_error_o                      sticky watchdog expiry flag
//   state_o                           current FSM state (debug)
module render_scheduler #(
    parameter int unsigned WDOG_W = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_tick_i,
    input  logic        enable_map_i,
    output logic        logic_start_o,
    output logic        fpv_start_o,
    output logic        map_start_o,
    input  logic        logic_done_i,
    input  logic        fpv_done_i,
    input  logic        map_done_i,
    input  logic [5:0]  logic_grid_x_i,
    input  logic [4:0]  logic_grid_y_i,
    input  logic [5:0]  fpv_grid_x_i,
    input  logic [4:0]  fpv_grid_y_i,
    input  logic [5:0]  map_grid_x_i,
    input  logic [4:0]  map_grid_y_i,
    output logic [5:0]  grid_x_o,
    output logic [4:0]  grid_y_o,
    input  logic [7:0]  fpv_vga_x_i,
    input  logic [6:0]  fpv_vga_y_i,
    input  logic [17:0] fpv_vga_colour_i,
    input  logic        fpv_vga_write_i,
    input  logic [7:0]  map_vga_x_i,
    input  logic [6:0]  map_vga_y_i,
    input  logic [17:0] map_vga_colour_i,
    input  logic        map_vga_write_i,
    output logic [7:0]  vga_x_o,
    output logic [6:0]  vga_y_o,
    output logic [17:0] vga_colour_o,
    output logic        vga_write_o,
    output logic        busy_o,
    output logic [7:0]  frame_count_o,
    output logic [7:0]  drop_count_o,
    output logic        wdog_error_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOGIC_START = 3'd1,
        LOGIC_WAIT  = 3'd2,
        FPV_START   = 3'd3,
        FPV_WAIT    = 3'd4,
        MAP_START   = 3'd5,
        MAP_WAIT    = 3'd6,
        FRAME_END   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                wdog_error_q, wdog_error_d;

    logic                in_wait;
    logic                done_sel;
    logic [WDOG_W-1:0]   wdog_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            wdog_q        <= '0;
            frame_count_q <= 8'd0;
            drop_count_q  <= 8'd0;
            wdog_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            wdog_q        <= wdog_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            wdog_error_q  <= wdog_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        wdog_d        = wdog_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        wdog_error_d  = wdog_error_q;
        in_wait       = 1'b0;
        done_sel      = 1'b0;
        wdog_inc      = wdog_q + WDOG_W'(1);

        case (state_q)
            IDLE: begin
                if (frame_tick_i || pending_q) state_d = LOGIC_START;
                // Consuming the buffered tick: a tick arriving in this same
                // cycle is buffered again instead of being dropped.
                if (pending_q) pending_d = frame_tick_i;
            end
            LOGIC_START: state_d = LOGIC_WAIT;
            LOGIC_WAIT: begin
                in_wait  = 1'b1;
                done_sel = logic_done_i;
                if (logic_done_i) state_d = FPV_START;
            end
            FPV_START: state_d = FPV_WAIT;
            FPV_WAIT: begin
                in_wait  = 1'b1;
                done_sel = fpv_done_i;
                if (fpv_done_i) state_d = enable_map_i ? MAP_START : FRAME_END;
            end
            MAP_START: state_d = MAP_WAIT;
            MAP_WAIT: begin
                in_wait  = 1'b1;
                done_sel = map_done_i;
                if (map_done_i) state_d = FRAME_END;
            end
            FRAME_END: begin
                state_d       = IDLE;
                frame_count_d = frame_count_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // A done pulse takes priority over expiry in the same cycle. Expiry
        // fires on the WAIT cycle in which the counter reaches all-ones.
        if (in_wait && !done_sel) begin
            wdog_d = wdog_inc;
            if (wdog_inc == '1) begin
                wdog_error_d = 1'b1;
                state_d      = FRAME_END;
            end
        end

        if (state_d == LOGIC_START || state_d == FPV_START || state_d == MAP_START)
            wdog_d = '0;

        // Only one tick is buffered. Any extra tick during a frame is a drop.
        if (state_q != IDLE && frame_tick_i) begin
            if (!pending_q) pending_d = 1'b1;
            else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Outputs decode state only, so an asynchronous reset clears them at once.
    always_comb begin
        grid_x_o     = 6'd0;
        grid_y_o     = 5'd0;
        vga_x_o      = 8'd0;
        vga_y_o      = 7'd0;
        vga_colour_o = 18'd0;
        vga_write_o  = 1'b0;
        case (state_q)
            LOGIC_START, LOGIC_WAIT: begin
                grid_x_o = logic_grid_x_i;
                grid_y_o = logic_grid_y_i;
            end
            FPV_START, FPV_WAIT: begin
                grid_x_o     = fpv_grid_x_i;
                grid_y_o     = fpv_grid_y_i;
                vga_x_o      = fpv_vga_x_i;
                vga_y_o      = fpv_vga_y_i;
                vga_colour_o = fpv_vga_colour_i;
                vga_write_o  = fpv_vga_write_i;
            end
            MAP_START, MAP_WAIT: begin
                grid_x_o     = map_grid_x_i;
                grid_y_o     = map_grid_y_i;
                vga_x_o      = map_vga_x_i;
                vga_y_o      = map_vga_y_i;
                vga_colour_o = map_vga_colour_i;
                vga_write_o  = map_vga_write_i;
            end
            default: ;
        endcase
    end

    assign logic_start_o = (state_q == LOGIC_START);
    assign fpv_start_o   = (state_q == FPV_START);
    assign map_start_o   = (state_q == MAP_START);
    assign busy_o        = (state_q != IDLE);
    assign frame_count_o = frame_count_q;
    assign drop_count_o  = drop_count_q;
    assign wdog_error_o  = wdog_error_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler (instantiated with a 4-bit watchdog).
// The stimulus pushes the expected start / frame-end events into exp_q. A
// monitor pops one entry each time the DUT shows one of those events. Each
// event word is {frame_end, logic_start, fpv_start, map_start, frame_count,
// drop_count, wdog_error}.
module tb_render_scheduler;
  localparam int W = 21;
  localparam logic [3:0] EV_L = 4'b0100;
  localparam logic [3:0] EV_F = 4'b0010;
  localparam logic [3:0] EV_M = 4'b0001;
  localparam logic [3:0] EV_E = 4'b1000;

  logic clk, rst_n, frame_tick, enable_map;
  logic logic_start, fpv_start, map_start;
  logic logic_done, fpv_done, map_done;
  logic [5:0] logic_gx, fpv_gx, map_gx, grid_x;
  logic [4:0] logic_gy, fpv_gy, map_gy, grid_y;
  logic [7:0] fpv_vx, map_vx, vga_x;
  logic [6:0] fpv_vy, map_vy, vga_y;
  logic [17:0] fpv_col, map_col, vga_colour;
  logic fpv_wr, map_wr, vga_write;
  logic busy, wdog_error;
  logic [7:0] frame_count, drop_count;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int vga_seen = 0;

  render_scheduler #(.WDOG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick), .enable_map_i(enable_map),
    .logic_start_o(logic_start), .fpv_start_o(fpv_start), .map_start_o(map_start),
    .logic_done_i(logic_done), .fpv_done_i(fpv_done), .map_done_i(map_done),
    .logic_grid_x_i(logic_gx), .logic_grid_y_i(logic_gy),
    .fpv_grid_x_i(fpv_gx), .fpv_grid_y_i(fpv_gy),
    .map_grid_x_i(map_gx), .map_grid_y_i(map_gy),
    .grid_x_o(grid_x), .grid_y_o(grid_y),
    .fpv_vga_x_i(fpv_vx), .fpv_vga_y_i(fpv_vy), .fpv_vga_colour_i(fpv_col), .fpv_vga_write_i(fpv_wr),
    .map_vga_x_i(map_vx), .map_vga_y_i(map_vy), .map_vga_colour_i(map_col), .map_vga_write_i(map_wr),
    .vga_x_o(vga_x), .vga_y_o(vga_y), .vga_colour_o(vga_colour), .vga_write_o(vga_write),
    .busy_o(busy), .frame_count_o(frame_count), .drop_count_o(drop_count),
    .wdog_error_o(wdog_error), .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // checking helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [7:0] fc,
                                      input logic [7:0] dc, input logic e);
    return {k, fc, dc, e};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] obs, e;
    if (vga_write === 1'b1) vga_seen++;
    if (rst_n && (logic_start || fpv_start || map_start || state == 3'd7)) begin
      obs = {state == 3'd7, logic_start, fpv_start, map_start, frame_count, drop_count, wdog_error};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event: got %h expected none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          failures++;
          $display("FAIL event: got %h expected %h", obs, e);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_done(input int which);
    logic_done = (which == 1);
    fpv_done   = (which == 2);
    map_done   = (which == 3);
    step(1);
    logic_done = 1'b0;
    fpv_done   = 1'b0;
    map_done   = 1'b0;
  endtask

  task automatic push4(input logic [7:0] fc, input logic [7:0] dc, input logic e, input logic with_map);
    exp_q.push_back(ev(EV_L, fc, dc, e));
    exp_q.push_back(ev(EV_F, fc, dc, e));
    if (with_map) exp_q.push_back(ev(EV_M, fc, dc, e));
    exp_q.push_back(ev(EV_E, fc, dc, e));
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; enable_map = 1'b1;
    logic_done = 1'b0; fpv_done = 1'b0; map_done = 1'b0;
    logic_gx = 6'h11; logic_gy = 5'h0A;
    fpv_gx = 6'h2A; fpv_gy = 5'h13;
    map_gx = 6'h3C; map_gy = 5'h1E;
    fpv_vx = 8'hA5; fpv_vy = 7'h5A; fpv_col = 18'h3C0F1; fpv_wr = 1'b1;
    map_vx = 8'h3B; map_vy = 7'h21; map_col = 18'h1ABCD; map_wr = 1'b1;

    // reset state
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_starts", {logic_start, fpv_start, map_start}, 0);
    chk("rst_vga_write", vga_write, 0);
    chk("rst_grid", {grid_x, grid_y}, 0);
    chk("rst_counts", {frame_count, drop_count, wdog_error}, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_start", state, 0);

    // full frame with minimap
    push4(8'd0, 8'd0, 1'b0, 1'b1);
    pulse_tick();
    chk("t1_logic_start_state", state, 1);
    step(1);
    chk("t1_logic_grid", {grid_x, grid_y}, {6'h11, 5'h0A});
    chk("t1_logic_no_vga", vga_write, 0);
    step(2);
    pulse_done(1);
    chk("t1_fpv_start_state", state, 3);
    step(1);
    chk("t1_fpv_grid", {grid_x, grid_y}, {6'h2A, 5'h13});
    chk("t1_fpv_vga", {vga_x, vga_y, vga_colour, vga_write}, {8'hA5, 7'h5A, 18'h3C0F1, 1'b1});
    step(9);
    pulse_done(2);
    chk("t1_map_start_state", state, 5);
    step(1);
    chk("t1_map_grid", {grid_x, grid_y}, {6'h3C, 5'h1E});
    chk("t1_map_vga", {vga_x, vga_y, vga_colour, vga_write}, {8'h3B, 7'h21, 18'h1ABCD, 1'b1});
    step(4);
    pulse_done(3);
    chk("t1_frame_end", state, 7);
    step(1);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_idle_outputs", {grid_x, grid_y, vga_write}, 0);

    // minimap disabled, map client holds its write high
    enable_map = 1'b0; fpv_wr = 1'b0; map_wr = 1'b1;
    vga_seen = 0;
    push4(8'd1, 8'd0, 1'b0, 1'b0);
    pulse_tick();
    step(1);
    pulse_done(1);
    step(3);
    pulse_done(2);
    chk("t2_fpv_to_frame_end", state, 7);
    step(1);
    chk("t2_no_vga_write", vga_seen, 0);
    chk("t2_frame_count", frame_count, 2);

    // tick buffering: three ticks in one frame, then re-arm on the consume cycle
    push4(8'd2, 8'd0, 1'b0, 1'b0);
    exp_q.pop_back(); exp_q.pop_back();
    exp_q.push_back(ev(EV_F, 8'd2, 8'd2, 1'b0));
    exp_q.push_back(ev(EV_E, 8'd2, 8'd2, 1'b0));
    push4(8'd3, 8'd2, 1'b0, 1'b0);
    push4(8'd4, 8'd2, 1'b0, 1'b0);
    pulse_tick();
    step(1);
    pulse_tick(); pulse_tick(); pulse_tick();
    chk("t3_drop_count", drop_count, 2);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(1);
    chk("t3_idle_between", state, 0);
    pulse_tick();
    chk("t3_second_frame_start", state, 1);
    chk("t3_no_drop_on_consume", drop_count, 2);
    step(1);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(1);
    step(1);
    chk("t3_third_frame_start", state, 1);
    step(1);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(3);
    chk("t3_settled_idle", state, 0);
    chk("t3_frame_count", frame_count, 5);

    // done in START cycle ignored, then watchdog expiry
    exp_q.push_back(ev(EV_L, 8'd5, 8'd2, 1'b0));
    exp_q.push_back(ev(EV_F, 8'd5, 8'd2, 1'b0));
    exp_q.push_back(ev(EV_E, 8'd5, 8'd2, 1'b1));
    pulse_tick();
    step(1);
    pulse_done(1);
    chk("t4_in_fpv_start", state, 3);
    pulse_done(2);
    chk("t4_done_ignored", state, 4);
    step(14);
    chk("t4_wait_cycle15", {state, wdog_error}, {3'd4, 1'b0});
    step(1);
    chk("t4_expired", {state, wdog_error}, {3'd7, 1'b1});
    step(1);
    chk("t4_frame_count", frame_count, 6);
    enable_map = 1'b1;
    push4(8'd6, 8'd2, 1'b1, 1'b1);
    pulse_tick();
    step(1);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(1);
    pulse_done(3);
    step(1);
    chk("t4_after_normal", {frame_count, wdog_error}, {8'd7, 1'b1});

    // reset in MAP_WAIT with drop_count 5
    exp_q.push_back(ev(EV_L, 8'd7, 8'd2, 1'b1));
    exp_q.push_back(ev(EV_F, 8'd7, 8'd5, 1'b1));
    exp_q.push_back(ev(EV_M, 8'd7, 8'd5, 1'b1));
    pulse_tick();
    step(1);
    pulse_tick(); pulse_tick(); pulse_tick(); pulse_tick();
    chk("t5_drop_count", drop_count, 5);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(3);
    chk("t5_in_map_wait", {state, vga_write}, {3'd6, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_state", {state, busy}, 0);
    chk("t5_rst_starts", {logic_start, fpv_start, map_start}, 0);
    chk("t5_rst_vga_grid", {vga_write, grid_x, grid_y}, 0);
    chk("t5_rst_counts", {frame_count, drop_count, wdog_error}, 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("t5_no_restart", state, 0);
    push4(8'd0, 8'd0, 1'b0, 1'b1);
    pulse_tick();
    step(1);
    pulse_done(1);
    step(1);
    pulse_done(2);
    step(1);
    pulse_done(3);
    step(2);
    chk("t5_fresh_frame", {state, frame_count}, {3'd0, 8'd1});

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter: WDOG_W, default 20, width of the per-client watchdog counter.
REQ-002 clock  in  1  system clock, all state on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 frame_tick  in  1  one-cycle pulse requesting a new frame.
REQ-005 enable_map  in  1  1 = draw minimap after first-person view.
REQ-006 logic_start/fpv_start/map_start  out  1 each  one-cycle start pulses to game-logic, draw_fpv and minimap clients.
REQ-007 logic_done/fpv_done/map_done  in  1 each  client completion pulses.
REQ-008 logic_grid_x/fpv_grid_x/map_grid_x  in  6 each; logic_grid_y/fpv_grid_y/map_grid_y  in  5 each  client grid addresses.
REQ-009 grid_x  out  6; grid_y  out  5  muxed grid memory address.
REQ-010 fpv_vga_x/map_vga_x  in  8; fpv_vga_y/map_vga_y  in  7; fpv_vga_colour/map_vga_colour  in  18; fpv_vga_write/map_vga_write  in  1.
REQ-011 vga_x  out  8; vga_y  out  7; vga_colour  out  18; vga_write  out  1  muxed VGA adapter port.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 frame_count  out  8  completed frames, wraps 255->0.
REQ-014 drop_count  out  8  dropped frame ticks, saturates at 255.
REQ-015 wdog_error  out  1  sticky, set on any watchdog expiry.

Function
REQ-016 States: IDLE, LOGIC_START, LOGIC_WAIT, FPV_START, FPV_WAIT, MAP_START, MAP_WAIT, FRAME_END.
REQ-017 IDLE -> LOGIC_START on frame_tick or on pending=1; else stay.
REQ-018 LOGIC_START -> LOGIC_WAIT; FPV_START -> FPV_WAIT; MAP_START -> MAP_WAIT, each unconditionally after one cycle.
REQ-019 LOGIC_WAIT -> FPV_START on logic_done.
REQ-020 FPV_WAIT on fpv_done -> MAP_START if enable_map=1 that cycle, else FRAME_END.
REQ-021 MAP_WAIT -> FRAME_END on map_done; FRAME_END -> IDLE, frame_count +1 in FRAME_END.
REQ-022 x_start is high exactly in state X_START (Moore); done inputs are ignored outside the matching WAIT state, including in the START cycle.
REQ-023 Tick buffering: frame_tick in any non-IDLE state (FRAME_END included) sets pending if clear; if pending already set, drop_count +1 (saturating); tick in IDLE starts a frame and leaves pending unchanged.
REQ-024 pending clears on the IDLE cycle it is consumed; a tick in that same cycle sets pending again (no drop).
REQ-025 Watchdog: counter clears on entry to each START state and increments every WAIT cycle; when it reaches all-ones without the matching done, wdog_error sets and state -> FRAME_END (frame_count still increments).
REQ-026 Grid mux (combinational on state): LOGIC_* -> logic_grid, FPV_* -> fpv_grid, MAP_* -> map_grid, else 0.
REQ-027 VGA mux (combinational on state): FPV_* -> fpv_vga_*, MAP_* -> map_vga_*, else vga_write=0 and x/y/colour=0.
REQ-028 Client vga_write asserted outside its owning states never reaches vga_write.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, pending 0, watchdog 0, frame_count 0, drop_count 0, wdog_error 0; all start pulses 0, busy 0, vga_write 0, grid_x/grid_y 0.
REQ-030 Reset mid-frame abandons the frame with no completion pulse; the first frame after release requires a fresh frame_tick.

Verification
REQ-031 Tick in IDLE, logic_done at +3, fpv_done at +10, enable_map=1, map_done at +5 -> exactly one pulse each of logic/fpv/map_start in order, frame_count=1, busy low after FRAME_END.
REQ-032 enable_map=0 -> map_start never pulses, FPV_WAIT -> FRAME_END, map_vga_write=1 held throughout never appears on vga_write.
REQ-033 Three ticks during one frame -> pending set, drop_count=2, second frame starts on IDLE cycle immediately after FRAME_END.
REQ-034 WDOG_W=4, fpv_done never asserted -> after 15 FPV_WAIT cycles wdog_error=1, state FRAME_END, frame_count +1, next tick runs normally with wdog_error still 1.
REQ-035 fpv_done asserted in FPV_START cycle only -> ignored, FSM remains in FPV_WAIT.
REQ-036 reset=0 asserted in MAP_WAIT with drop_count=5 -> all outputs 0 immediately (before next clock edge), drop_count=0, no start pulse until new frame_tick.
